// File: rtl/axil_master_port.sv
// axil_master_port
//
// Single-outstanding AXI4-Lite initiator. A client presents one word request
// on a valid/ready port; the block turns it into an AXI-Lite read or write,
// waits for the response and returns it on a held valid/ready response port.
// Exactly one transaction is in flight at a time.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (req_ready high only in idle)
//   req_write                1 = write, 0 = read
//   req_addr                 byte address, must be word aligned
//   req_wdata, req_wstrb     write data and byte strobes
//   rsp_valid/rsp_ready      response handshake, response held until taken
//   rsp_rdata                read data (0 for writes and errors)
//   rsp_err                  SLVERR/DECERR received or misaligned request
//   err_count                saturating count of error responses
//   m_axil_*                 AXI4-Lite master channels AW, W, B, AR, R

`timescale 1ns / 1ps

module axil_master_port #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0]  PROT       = 3'b000
) (
  input  logic                  aclk,
  input  logic                  aresetn,

  // Client request port
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,

  // Client response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [15:0]           err_count,

  // AXI4-Lite write address channel
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,

  // AXI4-Lite write data channel
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,

  // AXI4-Lite write response channel
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,

  // AXI4-Lite read address channel
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,

  // AXI4-Lite read data channel
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StWrAddrData = 3'd1;
  localparam logic [2:0] StWrResp     = 3'd2;
  localparam logic [2:0] StRdAddr     = 3'd3;
  localparam logic [2:0] StRdData     = 3'd4;
  localparam logic [2:0] StResp       = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [15:0]           err_count_q, err_count_d;
  logic                  err_inc;
  logic                  aw_done;
  logic                  w_done;

  // A channel counts as done once its valid has dropped or its handshake
  // happens this cycle; AW and W may complete in either order.
  assign aw_done = !awvalid_q || m_axil_awready;
  assign w_done  = !wvalid_q  || m_axil_wready;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    araddr_d    = araddr_q;
    err_inc     = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_addr[1:0] != 2'b00) begin
            // Misaligned: answer locally, no AXI traffic.
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            err_inc     = 1'b1;
          end else if (req_write) begin
            state_d   = StWrAddrData;
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            wstrb_d   = req_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StRdAddr;
            araddr_d  = req_addr;
            arvalid_d = 1'b1;
          end
        end
      end

      StWrAddrData: begin
        if (m_axil_awready) awvalid_d = 1'b0;
        if (m_axil_wready)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = StWrResp;
          bready_d = 1'b1;
        end
      end

      StWrResp: begin
        if (m_axil_bvalid) begin
          state_d     = StResp;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (m_axil_bresp != 2'b00);
          rsp_rdata_d = '0;
          err_inc     = (m_axil_bresp != 2'b00);
        end
      end

      StRdAddr: begin
        if (m_axil_arready) begin
          state_d   = StRdData;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end

      StRdData: begin
        if (m_axil_rvalid) begin
          state_d     = StResp;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (m_axil_rresp != 2'b00);
          // Error responses never leak slave data to the client.
          rsp_rdata_d = (m_axil_rresp != 2'b00) ? '0 : m_axil_rdata;
          err_inc     = (m_axil_rresp != 2'b00);
        end
      end

      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = StIdle;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

    err_count_d = err_count_q;
    if (err_inc && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      araddr_q    <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      araddr_q    <= araddr_d;
      err_count_q <= err_count_d;
    end
  end

  // Gated by aresetn so the client sees no acceptance while reset is held.
  assign req_ready      = (state_q == StIdle) && aresetn;

  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign err_count      = err_count_q;

  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = PROT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = PROT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_port.sv
// Bench for axil_master_port: a transaction-level model predicts, per request,
// which AXI phases must be active and what the response must be; every cycle
// the DUT outputs are compared against those predictions. A small AXI-Lite
// slave model with configurable or random delays sits on the master side.

`timescale 1ns / 1ps

module tb_axil_master_port;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] err_count;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [3:0]  m_axil_wstrb;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  axil_master_port dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .err_count(err_count),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  req_t cq[$];

  // Transaction model
  req_t        cur;
  bit          busy, aw_pend, w_pend, ar_pend, b_pend, r_pend, rsp_pend;
  logic [31:0] exp_rdata;
  bit          exp_err;
  int unsigned model_err;
  logic [31:0] ref_mem [logic [31:0]];

  // Slave model
  logic [31:0] slv_mem [logic [31:0]];
  bit          s_aw_got, s_w_got, s_ar_got;
  int          s_aw_cnt, s_w_cnt, s_ar_cnt, s_b_cnt, s_r_cnt;
  logic [31:0] s_awaddr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;

  // Knobs
  int aw_dly, w_dly, ar_dly, b_dly, r_dly;
  bit rand_dly, stray_en, rr_random;
  int rr_hold, rr_cnt;

  // Event edge numbers and last response
  int          t_acc, t_aw, t_w, t_ar, t_b, t_r, t_rise, t_rsp;
  bit          axi_seen, prev_rsp_valid;
  logic [31:0] last_rdata;
  logic        last_err;
  logic [15:0] last_cnt;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  function automatic bit err_region(input logic [31:0] a);
    return a[11:8] == 4'hF;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] slv_read(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
  endfunction

  function automatic void err_bump();
    if (model_err < 65535) model_err++;
  endfunction

  task automatic push_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb);
    req_t r;
    r.wr = wr; r.addr = addr; r.wdata = wdata; r.strb = strb;
    cq.push_back(r);
  endtask

  task automatic push_rand_req();
    int unsigned idx = $urandom_range(0, 15);
    int unsigned k   = $urandom_range(0, 9);
    logic [31:0] a;
    if (k == 0)      a = (32'(idx) << 2) | 32'($urandom_range(1, 3));
    else if (k == 1) a = 32'hF00 | (32'(idx) << 2);
    else             a = 32'(idx) << 2;
    push_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
  endtask

  // One clock cycle: compare outputs, drive inputs, then book the handshakes
  // that the coming rising edge will complete.
  task automatic step();
    bit hs_req, hs_aw, hs_w, hs_b, hs_ar, hs_r, hs_rsp;
    @(negedge aclk);

    check("req_ready", req_ready, !busy);
    check("awvalid", m_axil_awvalid, aw_pend);
    check("wvalid", m_axil_wvalid, w_pend);
    check("arvalid", m_axil_arvalid, ar_pend);
    check("bready", m_axil_bready, b_pend);
    check("rready", m_axil_rready, r_pend);
    check("rsp_valid", rsp_valid, rsp_pend);
    check("err_count", err_count, 16'(model_err));
    if (m_axil_awvalid) check("awaddr", m_axil_awaddr, cur.addr);
    if (m_axil_wvalid) begin
      check("wdata", m_axil_wdata, cur.wdata);
      check("wstrb", m_axil_wstrb, cur.strb);
    end
    if (m_axil_arvalid) check("araddr", m_axil_araddr, cur.addr);
    if (rsp_valid) begin
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_err", rsp_err, exp_err);
      if (!prev_rsp_valid) t_rise = cyc;
    end
    prev_rsp_valid = rsp_valid;
    if (m_axil_awvalid || m_axil_wvalid || m_axil_arvalid) axi_seen = 1;

    // Client
    if (cq.size() > 0) begin
      req_valid = 1'b1;
      req_write = cq[0].wr;
      req_addr  = cq[0].addr;
      req_wdata = cq[0].wdata;
      req_wstrb = cq[0].strb;
    end else begin
      req_valid = 1'b0;
    end
    if (rr_random) rsp_ready = 1'($urandom_range(0, 1));
    else           rsp_ready = !(rsp_valid && rr_cnt < rr_hold);
    if (rsp_valid && !rsp_ready) rr_cnt++;

    // Slave
    if (m_axil_awvalid && !s_aw_got) begin
      m_axil_awready = (s_aw_cnt >= aw_dly);
      if (!m_axil_awready) s_aw_cnt++;
    end else m_axil_awready = 1'b0;
    if (m_axil_wvalid && !s_w_got) begin
      m_axil_wready = (s_w_cnt >= w_dly);
      if (!m_axil_wready) s_w_cnt++;
    end else m_axil_wready = 1'b0;
    if (m_axil_arvalid && !s_ar_got) begin
      m_axil_arready = (s_ar_cnt >= ar_dly);
      if (!m_axil_arready) s_ar_cnt++;
    end else m_axil_arready = 1'b0;
    if (s_aw_got && s_w_got) begin
      m_axil_bvalid = (s_b_cnt >= b_dly);
      m_axil_bresp  = m_axil_bvalid ? s_bresp : 2'b00;
      if (!m_axil_bvalid) s_b_cnt++;
    end else begin
      m_axil_bvalid = stray_en && ($urandom_range(0, 3) == 0);
      m_axil_bresp  = 2'($urandom_range(0, 3));
    end
    if (s_ar_got) begin
      m_axil_rvalid = (s_r_cnt >= r_dly);
      m_axil_rdata  = m_axil_rvalid ? s_rdata : $urandom;
      m_axil_rresp  = m_axil_rvalid ? s_rresp : 2'b00;
      if (!m_axil_rvalid) s_r_cnt++;
    end else begin
      m_axil_rvalid = stray_en && ($urandom_range(0, 3) == 0);
      m_axil_rdata  = $urandom;
      m_axil_rresp  = 2'($urandom_range(0, 3));
    end

    hs_req = req_valid && req_ready;
    hs_aw  = m_axil_awvalid && m_axil_awready;
    hs_w   = m_axil_wvalid && m_axil_wready;
    hs_b   = m_axil_bvalid && m_axil_bready;
    hs_ar  = m_axil_arvalid && m_axil_arready;
    hs_r   = m_axil_rvalid && m_axil_rready;
    hs_rsp = rsp_valid && rsp_ready;

    if (hs_rsp) begin
      t_rsp      = cyc + 1;
      last_rdata = rsp_rdata;
      last_err   = rsp_err;
      last_cnt   = err_count;
      rsp_pend   = 0;
      busy       = 0;
      rr_cnt     = 0;
    end
    if (hs_req) begin
      cur      = cq.pop_front();
      busy     = 1;
      t_acc    = cyc + 1;
      axi_seen = 0;
      if (rand_dly) begin
        aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
        ar_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
        r_dly  = $urandom_range(0, 3);
      end
      if (cur.addr[1:0] != 2'b00) begin
        exp_err = 1; exp_rdata = 0; rsp_pend = 1;
        err_bump();
      end else if (cur.wr) begin
        aw_pend = 1; w_pend = 1; exp_rdata = 0;
        exp_err = err_region(cur.addr);
        if (!exp_err) ref_mem[cur.addr] = merge(ref_read(cur.addr), cur.wdata, cur.strb);
      end else begin
        ar_pend   = 1;
        exp_err   = err_region(cur.addr);
        exp_rdata = exp_err ? 32'h0 : ref_read(cur.addr);
      end
    end
    if (hs_aw) begin
      t_aw = cyc + 1; aw_pend = 0; s_aw_got = 1; s_aw_cnt = 0;
      s_awaddr = m_axil_awaddr;
      s_bresp  = err_region(m_axil_awaddr) ? 2'b10 : 2'b00;
    end
    if (hs_w) begin
      t_w = cyc + 1; w_pend = 0; s_w_got = 1; s_w_cnt = 0;
      s_wdata = m_axil_wdata; s_wstrb = m_axil_wstrb;
    end
    if ((hs_aw || hs_w) && !aw_pend && !w_pend) b_pend = 1;
    if (hs_b) begin
      t_b = cyc + 1; b_pend = 0; rsp_pend = 1;
      if (s_bresp == 2'b00) slv_mem[s_awaddr] = merge(slv_read(s_awaddr), s_wdata, s_wstrb);
      s_aw_got = 0; s_w_got = 0; s_b_cnt = 0;
      if (exp_err) err_bump();
    end
    if (hs_ar) begin
      t_ar = cyc + 1; ar_pend = 0; r_pend = 1; s_ar_got = 1; s_ar_cnt = 0;
      s_rresp = err_region(m_axil_araddr) ? 2'b11 : 2'b00;
      s_rdata = err_region(m_axil_araddr) ? $urandom : slv_read(m_axil_araddr);
    end
    if (hs_r) begin
      t_r = cyc + 1; r_pend = 0; rsp_pend = 1; s_ar_got = 0; s_r_cnt = 0;
      if (exp_err) err_bump();
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((cq.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check({name, "_timeout"}, (cq.size() != 0 || busy), 0);
  endtask

  task automatic clear_models();
    cq.delete();
    busy = 0; aw_pend = 0; w_pend = 0; ar_pend = 0; b_pend = 0; r_pend = 0; rsp_pend = 0;
    s_aw_got = 0; s_w_got = 0; s_ar_got = 0;
    s_aw_cnt = 0; s_w_cnt = 0; s_ar_cnt = 0; s_b_cnt = 0; s_r_cnt = 0;
    model_err = 0; prev_rsp_valid = 0; rr_cnt = 0;
    req_valid = 0; rsp_ready = 0;
    m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
    m_axil_bvalid = 0; m_axil_bresp = 0; m_axil_rvalid = 0; m_axil_rresp = 0;
    m_axil_rdata = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    clear_models();
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
    rand_dly = 0; stray_en = 0; rr_random = 0; rr_hold = 0;
    cur.wr = 0; cur.addr = 0; cur.wdata = 0; cur.strb = 0;
    exp_rdata = 0; exp_err = 0;
    ref_mem[32'h100] = 32'hDEADBEEF;
    slv_mem[32'h100] = 32'hDEADBEEF;

    repeat (2) @(negedge aclk);
    check("rst_req_ready", req_ready, 0);
    check("rst_awvalid", m_axil_awvalid, 0);
    check("rst_wvalid", m_axil_wvalid, 0);
    check("rst_arvalid", m_axil_arvalid, 0);
    check("rst_bready", m_axil_bready, 0);
    check("rst_rready", m_axil_rready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_err_count", err_count, 0);
    check("rst_awaddr", m_axil_awaddr, 0);
    aresetn = 1'b1;
    step();

    // Aligned read, zero-wait slave
    push_req(0, 32'h100, 0, 0);
    drain(20, "rd");
    check("rd_ar_lat", t_ar - t_acc, 1);
    check("rd_r_lat", t_r - t_acc, 2);
    check("rd_rsp_rise", t_rise - t_r, 0);
    check("rd_rsp_lat", t_rsp - t_acc, 3);
    check("rd_rdata", last_rdata, 32'hDEADBEEF);
    check("rd_err", last_err, 0);

    // Write with W handshake at cycle 1 and AW at cycle 3
    aw_dly = 2;
    push_req(1, 32'h8, 32'h12345678, 4'hF);
    drain(20, "wr_split");
    aw_dly = 0;
    check("wr_w_lat", t_w - t_acc, 1);
    check("wr_aw_lat", t_aw - t_acc, 3);
    check("wr_b_lat", t_b - t_acc, 4);
    check("wr_rsp_lat", t_rsp - t_acc, 5);
    check("wr_err", last_err, 0);
    check("wr_rdata", last_rdata, 0);
    push_req(0, 32'h8, 0, 0);
    drain(20, "rd_back");
    check("rd_back_rdata", last_rdata, 32'h12345678);

    // Error write then error read
    push_req(1, 32'hF00, 32'hCAFEF00D, 4'hF);
    drain(20, "wr_err");
    check("wr_err_flag", last_err, 1);
    check("wr_err_cnt", last_cnt, 1);
    push_req(0, 32'hF04, 0, 0);
    drain(20, "rd_err");
    check("rd_err_rdata", last_rdata, 0);
    check("rd_err_flag", last_err, 1);
    check("rd_err_cnt", last_cnt, 2);

    // Misaligned read
    push_req(0, 32'h102, 0, 0);
    drain(20, "mis");
    check("mis_rise", t_rise - t_acc, 0);
    check("mis_no_axi", axi_seen, 0);
    check("mis_err", last_err, 1);
    check("mis_cnt", last_cnt, 3);
    check("mis_rsp_lat", t_rsp - t_acc, 1);

    // Response backpressure for 5 cycles
    rr_hold = 5;
    push_req(0, 32'h8, 0, 0);
    drain(30, "bp");
    rr_hold = 0;
    check("bp_hold", t_rsp - t_rise, 6);
    check("bp_rdata", last_rdata, 32'h12345678);

    // Randomised traffic
    rand_dly = 1; stray_en = 1; rr_random = 1;
    repeat (1500) begin
      if (cq.size() == 0 && $urandom_range(0, 1) == 0) push_rand_req();
      step();
    end
    drain(300, "rand");
    rand_dly = 0; stray_en = 0; rr_random = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; r_dly = 0;

    // Reset while arvalid is high
    ar_dly = 30;
    push_req(0, 32'h8, 0, 0);
    for (int n = 0; n < 10 && !m_axil_arvalid; n++) step();
    check("rst_mid_arvalid_seen", m_axil_arvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    check("rst_mid_arvalid", m_axil_arvalid, 0);
    check("rst_mid_req_ready", req_ready, 0);
    check("rst_mid_err_count", err_count, 0);
    clear_models();
    ar_dly = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    push_req(0, 32'h100, 0, 0);
    drain(20, "post_rst");
    check("post_rst_rdata", last_rdata, 32'hDEADBEEF);
    check("post_rst_err", last_err, 0);
    check("post_rst_lat", t_rsp - t_acc, 3);
    check("post_rst_cnt", last_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_master_port.md
# axil_master_port

Single-outstanding AXI4-Lite initiator that turns a simple valid/ready word request port into AXI-Lite read and write transactions. It sits between a memory-requesting client (CPU data port, blitter, loader) and the AXI-Lite interconnect that serves the SDRAM bridge and peripheral slaves. Exactly one transaction is in flight at a time. Responses return on a held valid/ready response port.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of request and AXI ports
- DATA_WIDTH, 32, data width; only 32 is supported
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- PROT, 3'b000, constant driven on awprot/arprot

Ports:
- aclk  in  1  sole clock
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address; must be word aligned
- req_wdata  in  DATA_WIDTH  write data
- req_wstrb  in  STRB_WIDTH  write byte strobes
- rsp_valid  out  1  response present, held until rsp_ready
- rsp_ready  in  1  client accepts response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  1 = SLVERR/DECERR received or misaligned request
- err_count  out  16  saturating count of error responses
- m_axil_awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arprot, arvalid, arready, rdata, rresp, rvalid, rready: standard AXI4-Lite master signals with widths ADDR_WIDTH, 3, 1, 1, DATA_WIDTH, STRB_WIDTH, 1, 1, 2, 1, 1, ADDR_WIDTH, 3, 1, 1, DATA_WIDTH, 2, 1, 1.

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: req_ready = 1. All other states: req_ready = 0.
- Request accept (req_valid && req_ready):
  - Copy the address, write data and strobes into registers.
  - If req_addr[1:0] != 0: go to RESP with rsp_err = 1 and rsp_rdata = 0. No AXI traffic is issued.
  - Otherwise go to WR_ADDR_DATA if req_write, else RD_ADDR.
- WR_ADDR_DATA:
  - Assert awvalid and wvalid together.
  - Each valid drops independently on its own handshake.
  - Leave the state when both handshakes have completed; they may occur in the same cycle or in different cycles.
  - Go to WR_RESP.
- WR_RESP:
  - bready = 1.
  - On bvalid: rsp_err = (bresp != 0), rsp_rdata = 0. Go to RESP.
- RD_ADDR:
  - arvalid = 1 until arready. Then go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid: capture rdata. rsp_err = (rresp != 0). If rresp != 0, force rsp_rdata = 0. Go to RESP.
- RESP:
  - rsp_valid = 1 until rsp_ready. Then go to IDLE.
- AXI rule: no valid is deasserted before its ready. awaddr, wdata, wstrb and araddr are stable while their valid is high.
- err_count increments by 1 on every RESP entry with rsp_err = 1. It saturates at 16'hFFFF.
- bready and rready are low outside WR_RESP and RD_DATA. A stray bvalid or rvalid in any other state is ignored.

## Timing
- All outputs are registered, except req_ready, which decodes directly from the state register.
- Reset values: state IDLE; awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err = 0; rsp_rdata, err_count, all AXI address/data = 0; req_ready = 0 while aresetn is low, 1 after release.
- Reset asserted mid-transaction: every valid/ready drops immediately and the transaction is abandoned. The system resets the interconnect together with this block.
- Request accepted at edge T:
  - awvalid/wvalid (or arvalid) are high from T.
  - With a zero-wait slave: address handshake at T+1; bready/rready high after T+1; response handshake at T+2; rsp_valid high after T+2.
  - With rsp_ready already high: rsp handshake at T+3, and req_ready is high again after T+3.
- Misaligned request accepted at T: rsp_valid high after T.
- Throughput: at most one transaction per 4 cycles.

## Test plan
- Aligned read: addr 0x100, slave returns rdata 0xDEADBEEF, rresp 0 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid one cycle after the R handshake.
- Write with AW and W split: awready at cycle 3, wready at cycle 1 -> awvalid held until cycle 3; bready rises only after both handshakes; bresp 0 -> rsp_err 0, rsp_rdata 0.
- Write with bresp 2'b10 -> rsp_err 1, err_count 0 -> 1; the following read with rresp 2'b11 -> rsp_rdata 0, err_count 2.
- Misaligned read at 0x102 -> no arvalid at any time, rsp_valid after 1 cycle with rsp_err 1.
- Backpressure: rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable throughout, req_ready stays 0, no new AXI valid asserted.
- aresetn pulsed low while arvalid is high -> arvalid drops immediately; after release, req_ready = 1 and a fresh read completes normally.
